// File: rtl/axi_wr_master_burst_if.sv
// AXI write-channel bundle (AW/W/B) shared by the burst write master and its slave.
interface axi_wr_master_burst_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [7:0]                awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wlast;
  logic                      bvalid;
  logic [1:0]                bresp;
  logic                      bready;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/axi_wr_master_burst.sv
// Splits one (address, beat count) write request into boundary-safe AXI INCR bursts,
// with AW and W decoupled through a burst-length queue and bounded outstanding B.
module axi_wr_master_burst #(
  parameter int ADDR_WIDTH      = 26,
  parameter int DATA_WIDTH      = 32,
  parameter int LEN_WIDTH       = 16,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int BOUNDARY        = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    init_end,
  input  logic                    wr_trig,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [LEN_WIDTH-1:0]    wr_len,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  output logic                    wr_data_en,
  output logic                    wr_ready,
  output logic                    wr_done,
  output logic                    wr_err,
  axi_wr_master_burst_if.master   axi
);

  localparam int BPB    = DATA_WIDTH / 8;
  localparam int BPB_LG = $clog2(BPB);
  localparam int BND_LG = $clog2(BOUNDARY);
  localparam int BND_W  = BND_LG + 1;
  localparam int OST_W  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BPB - 1);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_WAIT, S_DRAIN, S_DONE} aw_state_t;

  aw_state_t               state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]    rem_q;
  logic [8:0]              beats_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [7:0]              awlen_q;
  logic [OST_W-1:0]        ost_q;
  logic [7:0]              q_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]        q_wr, q_rd;
  logic [OST_W-1:0]        q_cnt;
  logic [7:0]              w_cnt;
  logic                    w_loaded;
  logic                    err_q;

  logic                    accept, aw_hs, w_hs, b_hs, space, q_empty, w_pop;
  logic                    aw_valid, done_p;
  logic [7:0]              w_cur;
  logic [8:0]              calc_beats;
  logic [LEN_WIDTH-1:0]    rem_after;

  // Beats for the next burst: min(remaining, MAX_BURST, beats left before the boundary).
  function automatic logic [8:0] burst_beats(input logic [ADDR_WIDTH-1:0] a,
                                             input logic [LEN_WIDTH-1:0]  rem);
    logic [BND_W-1:0]     off, to_bnd;
    logic [LEN_WIDTH:0]   cap, rem_x;
    off    = BND_W'(a[BND_LG-1:0]);
    to_bnd = (BND_W'(BOUNDARY) - off) >> BPB_LG;
    cap    = (to_bnd < BND_W'(MAX_BURST)) ? (LEN_WIDTH+1)'(to_bnd) : (LEN_WIDTH+1)'(MAX_BURST);
    rem_x  = {1'b0, rem};
    return (rem_x < cap) ? 9'(rem_x) : 9'(cap);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept     = wr_trig & wr_ready & (wr_len != '0);
  assign aw_hs      = axi.awvalid & axi.awready;
  assign w_hs       = axi.wvalid & axi.wready;
  assign b_hs       = axi.bvalid & axi.bready;
  assign q_empty    = (q_cnt == '0);
  assign space      = (ost_q < OST_W'(MAX_OUTSTANDING)) && (q_cnt != OST_W'(MAX_OUTSTANDING));
  assign calc_beats = burst_beats(addr_q, rem_q);
  assign rem_after  = rem_q - LEN_WIDTH'(beats_q);
  // The queue head stays in place until its last beat, so its length seeds the counter.
  assign w_cur      = w_loaded ? w_cnt : q_mem[q_rd];
  assign w_pop      = w_hs && (w_cur == 8'd0);

  always_comb begin
    state_d  = state_q;
    aw_valid = 1'b0;
    done_p   = 1'b0;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CALC;
      S_CALC:  state_d = space ? S_AW : S_WAIT;
      S_WAIT:  if (space) state_d = S_AW;
      S_AW: begin
        aw_valid = 1'b1;
        if (aw_hs) state_d = (rem_after != '0) ? S_CALC : S_DRAIN;
      end
      S_DRAIN: if (ost_q == '0 && q_empty) state_d = S_DONE;
      S_DONE: begin
        done_p  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      beats_q  <= '0;
      awaddr_q <= '0;
      awlen_q  <= '0;
      ost_q    <= '0;
      q_wr     <= '0;
      q_rd     <= '0;
      q_cnt    <= '0;
      w_cnt    <= '0;
      w_loaded <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= wr_addr & ALIGN_MASK;
        rem_q  <= wr_len;
      end
      if (state_q == S_CALC) begin
        beats_q  <= calc_beats;
        awaddr_q <= addr_q;
        awlen_q  <= 8'(calc_beats - 9'd1);
      end
      if (aw_hs) begin
        addr_q <= addr_q + (ADDR_WIDTH'(beats_q) << BPB_LG);
        rem_q  <= rem_after;
        q_wr   <= ptr_inc(q_wr);
      end
      case ({aw_hs, b_hs})
        2'b10:   ost_q <= ost_q + 1'b1;
        2'b01:   ost_q <= ost_q - 1'b1;
        default: ost_q <= ost_q;
      endcase
      if (w_pop) q_rd <= ptr_inc(q_rd);
      case ({aw_hs, w_pop})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
      if (w_hs) begin
        if (w_cur == 8'd0) begin
          w_loaded <= 1'b0;
        end else begin
          w_cnt    <= w_cur - 8'd1;
          w_loaded <= 1'b1;
        end
      end
      if (accept)                          err_q <= 1'b0;
      if (b_hs && axi.bresp != 2'b00)      err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) q_mem[q_wr] <= awlen_q;
  end

  assign axi.awvalid = aw_valid;
  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = awlen_q;
  assign axi.awsize  = 3'(BPB_LG);
  assign axi.awburst = 2'b01;
  assign axi.wvalid  = !q_empty;
  assign axi.wdata   = wr_data;
  assign axi.wstrb   = wr_strb;
  assign axi.wlast   = axi.wvalid && (w_cur == 8'd0);
  assign axi.bready  = (ost_q != '0);

  assign wr_data_en  = w_hs;
  assign wr_ready    = (state_q == S_IDLE) & init_end;
  assign wr_done     = done_p;
  assign wr_err      = err_q;

endmodule

// File: tb/tb_axi_wr_master_burst.sv
// Directed + randomized bench for axi_wr_master_burst with a reactive AXI slave
// and a burst-split reference model computed from address/length arithmetic.
module tb_axi_wr_master_burst;
  localparam int AW = 26;
  localparam int DW = 32;
  localparam int LW = 16;
  localparam longint AMASK = (64'd1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_end = 1'b1;
  logic          wr_trig = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [LW-1:0] wr_len = '0;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_strb;
  logic          wr_data_en, wr_ready, wr_done, wr_err;

  axi_wr_master_burst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_wr_master_burst #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
    .MAX_BURST(16), .MAX_OUTSTANDING(4), .BOUNDARY(4096)
  ) dut (
    .clk(clk), .rst(rst), .init_end(init_end), .wr_trig(wr_trig),
    .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_data_en(wr_data_en), .wr_ready(wr_ready), .wr_done(wr_done), .wr_err(wr_err),
    .axi(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dat_of(input int unsigned i);
    return (i * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction
  function automatic logic [3:0] strb_of(input int unsigned i);
    return 4'((i * 7) + 3);
  endfunction

  // user FIFO (show-ahead): the head is beat number user_idx
  int unsigned user_idx = 0;
  assign wr_data = dat_of(user_idx);
  assign wr_strb = strb_of(user_idx);

  // reference expectations
  logic [AW-1:0] exp_aw_addr[$];
  logic [7:0]    exp_aw_len[$];
  bit            exp_last[$];

  // monitor state
  int unsigned aw_total = 0, w_beats = 0, wl_total = 0, done_count = 0, de_count = 0, cyc = 0;
  int          b_total = 0, last_b_cyc = 0, done_cyc = 0;
  int          extra_aw = 0, extra_w = 0;
  bit          aw_stall = 0, w_stall = 0, w_prev_last = 0;
  logic [AW-1:0] aw_prev_addr = '0;
  logic [7:0]    aw_prev_len = '0;
  bit          pop_f = 0, wl_f = 0, bh_f = 0;

  // slave knobs
  bit rnd = 0, b_hold = 0;
  int err_at = -1;
  int b_pending = 0;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (rst) begin
      bus.awready = 1'b0;
      bus.wready  = 1'b0;
      bus.bvalid  = 1'b0;
      bus.bresp   = 2'b00;
      b_pending   = 0;
      pop_f = 0; wl_f = 0; bh_f = 0;
    end else begin
      if (pop_f) user_idx++;
      if (wl_f) b_pending++;
      if (bh_f) begin
        b_pending--;
        bus.bvalid = 1'b0;
      end
      pop_f = 0; wl_f = 0; bh_f = 0;
      bus.awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.wready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!bus.bvalid && b_pending > 0 && !b_hold && (!rnd || $urandom_range(0, 1) == 1)) begin
        bus.bvalid = 1'b1;
        bus.bresp  = (b_total == err_at) ? 2'b10 : 2'b00;
      end
    end
  end

  // Handshakes seen here complete on the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      aw_stall = 0;
      w_stall  = 0;
    end else begin
      if (aw_stall) begin
        chk("aw_valid_hold", bus.awvalid, 1);
        chk("aw_addr_hold", bus.awaddr, aw_prev_addr);
        chk("aw_len_hold", bus.awlen, aw_prev_len);
      end
      if (w_stall) begin
        chk("w_valid_hold", bus.wvalid, 1);
        chk("w_last_hold", bus.wlast, w_prev_last);
      end
      if (bus.wvalid) chk("w_after_aw", aw_total > wl_total, 1);
      chk("data_en", wr_data_en, bus.wvalid & bus.wready);
      if (bus.awvalid) begin
        chk("awsize", bus.awsize, 3'd2);
        chk("awburst", bus.awburst, 2'b01);
      end
      if (bus.awvalid && bus.awready) begin
        if (exp_aw_addr.size() > 0) begin
          chk("awaddr", bus.awaddr, exp_aw_addr.pop_front());
          chk("awlen", bus.awlen, exp_aw_len.pop_front());
        end else extra_aw++;
        aw_total++;
      end
      if (bus.wvalid && bus.wready) begin
        chk("wdata", bus.wdata, dat_of(w_beats));
        chk("wstrb", bus.wstrb, strb_of(w_beats));
        if (exp_last.size() > 0) chk("wlast", bus.wlast, exp_last.pop_front());
        else extra_w++;
        w_beats++;
        if (bus.wlast) begin
          wl_total++;
          wl_f = 1;
        end
      end
      if (wr_data_en) begin
        de_count++;
        pop_f = 1;
      end
      if (bus.bvalid && bus.bready) begin
        b_total++;
        bh_f = 1;
        last_b_cyc = cyc;
      end
      if (wr_done) begin
        done_count++;
        done_cyc = cyc;
      end
      aw_stall     = bus.awvalid & !bus.awready;
      aw_prev_addr = bus.awaddr;
      aw_prev_len  = bus.awlen;
      w_stall      = bus.wvalid & !bus.wready;
      w_prev_last  = bus.wlast;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int unsigned aw_base, beat_base, b_base, done_base, de_base;
  int          n_bursts, n_len;

  // Splits a request by the address rules into expected bursts and beats.
  task automatic build_expect(input longint addr, input int len, output int nb);
    longint a;
    int rem, tb, b;
    a   = addr & AMASK & ~longint'(3);
    rem = len;
    nb  = 0;
    while (rem > 0) begin
      tb = int'((4096 - (a % 4096)) / 4);
      b  = rem;
      if (b > 16) b = 16;
      if (b > tb) b = tb;
      exp_aw_addr.push_back(AW'(a));
      exp_aw_len.push_back(8'(b - 1));
      for (int k = 0; k < b; k++) exp_last.push_back(k == b - 1);
      a   = (a + longint'(b) * 4) & AMASK;
      rem = rem - b;
      nb++;
    end
  endtask

  task automatic start_xfer(input longint addr, input int len);
    int guard;
    build_expect(addr, len, n_bursts);
    n_len = len;
    guard = 0;
    while (!wr_ready && guard < 1000) begin
      @(posedge clk); #2;
      guard++;
    end
    chk("wr_ready_wait", wr_ready, 1);
    aw_base = aw_total; beat_base = w_beats; b_base = b_total;
    done_base = done_count; de_base = de_count;
    wr_addr = AW'(addr);
    wr_len  = LW'(len);
    wr_trig = 1'b1;
    @(posedge clk); #2;
    wr_trig = 1'b0;
  endtask

  task automatic finish_xfer(input bit exp_err);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #1;
      if (done_count > done_base) break;
    end
    chk("done_seen", done_count - done_base, 1);
    chk("aw_count", aw_total - aw_base, n_bursts);
    chk("beat_count", w_beats - beat_base, n_len);
    chk("b_count", b_total - b_base, n_bursts);
    chk("wr_err", wr_err, exp_err);
    @(negedge clk); #1;
    chk("done_one_cycle", wr_done, 0);
    chk("ready_after_done", wr_ready, 1);
    chk("aw_left", exp_aw_addr.size(), 0);
    chk("w_left", exp_last.size(), 0);
    chk("aw_extra", extra_aw, 0);
    chk("w_extra", extra_w, 0);
  endtask

  initial begin
    int d;
    longint ra;
    int rl;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_awaddr", bus.awaddr, 0);
    chk("rst_awlen", bus.awlen, 0);
    chk("rst_done", wr_done, 0);
    chk("rst_err", wr_err, 0);
    chk("rst_data_en", wr_data_en, 0);
    chk("rst_ready_hi", wr_ready, 1);
    init_end = 1'b0;
    #1;
    chk("rst_ready_lo", wr_ready, 0);
    init_end = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;

    // single burst, no stalls
    start_xfer(64'h100, 8);
    finish_xfer(0);
    d = done_cyc - last_b_cyc;
    chk("done_after_b", (d >= 1 && d <= 2), 1);

    // splitting at MAX_BURST
    start_xfer(64'h0, 40);
    finish_xfer(0);
    chk("data_en_count", de_count - de_base, 40);

    // 4 KiB boundary crossing
    start_xfer(64'hFF0, 10);
    finish_xfer(0);

    // outstanding limit with B withheld
    b_hold = 1;
    start_xfer(64'h0, 128);
    repeat (200) @(posedge clk);
    @(negedge clk); #1;
    chk("ost_aw_issued", aw_total - aw_base, 4);
    chk("ost_awvalid_low", bus.awvalid, 0);
    b_hold = 0;
    finish_xfer(0);

    // error on the middle B response, then cleared by the next accept
    err_at = b_total + 1;
    start_xfer(64'h2000, 40);
    finish_xfer(1);
    err_at = -1;
    start_xfer(64'h3000, 8);
    chk("err_cleared", wr_err, 0);
    finish_xfer(0);

    // guards: zero length and init not complete
    aw_base = aw_total;
    wr_len = '0; wr_addr = AW'(64'h400); wr_trig = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("len0_no_aw", aw_total - aw_base, 0);
    chk("len0_ready", wr_ready, 1);
    wr_trig = 1'b0;
    init_end = 1'b0;
    wr_len = LW'(8); wr_trig = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("noinit_no_aw", aw_total - aw_base, 0);
    chk("noinit_ready", wr_ready, 0);
    wr_trig = 1'b0;
    #1;
    init_end = 1'b1;
    @(posedge clk); #2;

    // randomized backpressure and addresses, including wrap near the top
    rnd = 1;
    for (int t = 0; t < 12; t++) begin
      if (t % 4 == 3) ra = AMASK - longint'($urandom_range(0, 255));
      else            ra = longint'($urandom) & AMASK;
      rl = int'($urandom_range(1, 80));
      start_xfer(ra, rl);
      finish_xfer(0);
    end
    rnd = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
